reg_bank_loader: RTL and testbench
==================================

Name: reg_bank_loader

Overview:
- Write-side counterpart of the bus-B read mux: owns the AES working registers r0..r2 (128-bit) and r3 (64-bit), which the read mux selects from.
- Registers are loaded two ways: from the host by a 32-bit valid/ready word stream assembled into a full register, or by a single-cycle datapath write-back from busC.
- Outputs r0..r3 feed the bus-B read mux directly.

Parameters:
- HOST_W, 32, host word width. Must divide 64. Words per load: 128/HOST_W for r0..r2, 64/HOST_W for r3.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- host_valid  input  1  host word valid
- host_ready  output  1  block accepts a word this cycle
- host_data  input  HOST_W  host word, most significant word first
- host_addr  input  2  target register (0..3); sampled only on the first beat of a load
- WE_busC  input  1  datapath write-back enable
- SEL_busC  input  2  write-back target register
- busC  input  128  write-back data; r3 takes busC[63:0]
- r0, r1, r2  output  128  working registers
- r3  output  64  working register
- busy  output  1  a host load is in progress (state LOAD or COMMIT)
- load_done  output  1  one-cycle pulse, the cycle after a host load commits

Behaviour:
- Reset (rst=1 at an edge):
  - r0..r3=0, staging=0, word count=0, state=IDLE, load_done=0.
  - rst takes precedence over every other input.
  - A reset mid-load discards the partial load; no register is written.
- host_ready = (state==IDLE or LOAD). It is 1 from the first cycle after reset and 0 in COMMIT.
- A beat is accepted when host_valid and host_ready are both 1.
- States:
  - IDLE: an accepted beat latches host_addr as the target, sets staging = host_data in the low word, count=1, and moves to LOAD. If the target needs only 1 word (impossible for HOST_W<=32), it goes straight to COMMIT.
  - LOAD: each accepted beat does staging = {staging shifted left by HOST_W, host_data} and count+1. When the beat making count == N is accepted (N=4 for r0..r2, N=2 for r3 at HOST_W=32), go to COMMIT. No beat = hold.
  - COMMIT:
    - Write staging into the target register (r3 takes staging[63:0]), then go to IDLE; load_done=1 in the following cycle.
    - If WE_busC=1 and SEL_busC equals the target in the same cycle, the write-back wins. COMMIT stalls (no host write, stays in COMMIT) and retries next cycle, so the host value lands after the write-back.
- Datapath write-back:
  - With WE_busC=1, the register selected by SEL_busC takes busC in that edge, in any state.
  - A write-back to a register other than the commit target proceeds in parallel with the commit.
- Register latency: a value written at edge k is visible on r0..r3 after edge k; no combinational path from busC to the outputs.
- host_addr on non-first beats is ignored.
- Word order: with HOST_W=32, the first word lands in [127:96] for r0..r2 and in [63:32] for r3.

Decomposition:
- aes_pkg holds:
  - REG_W=128, R3_W=64
  - typedef enum logic [1:0] {R0,R1,R2,R3} reg_id_t
  - typedef enum {IDLE,LOAD,COMMIT} ldr_state_t
  - function words_for(reg_id_t) returning the beat count
- One sub-module, word_assembler: the staging shift register plus the beat counter, with a done flag when count reaches N. The FSM and register bank stay in reg_bank_loader.

Test Plan:
- Reset then host load to r1 with words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF, one per cycle:
  - busy rises with the first beat.
  - r1=0x00112233_44556677_8899AABB_CCDDEEFF after the COMMIT edge.
  - load_done pulses once; r0, r2, r3 stay 0.
- Host load to r3 with words 0xDEADBEEF, 0x01234567 → r3=0xDEADBEEF01234567, exactly 2 beats accepted; a third word is held off by host_ready=0 in COMMIT.
- Gapped host_valid (beats on cycles 0, 3, 4, 9) to r0 → same r0 result as the back-to-back case; busy stays 1 throughout.
- In COMMIT for r2, apply WE_busC=1, SEL_busC=2, busC=all-ones:
  - r2=all-ones at that edge; the commit stalls one cycle.
  - Then r2 = host value; load_done is one cycle late.
- In COMMIT for r2, apply WE_busC=1, SEL_busC=0, busC=0xA5 repeated:
  - r0=busC and r2=host value on the same edge.
  - load_done is on time.
- Assert rst after the 2nd of 4 beats to r1 (r1 preloaded via busC to 0x55..55) → r1=0, state IDLE, no load_done. A fresh 4-beat load then completes correctly.

Source files
------------

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared widths, register identifiers, loader state encoding
//               and the beat-count helper for the AES working-register bank.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam int REG_W = 128;
  localparam int R3_W  = 64;

  typedef enum logic [1:0] {R0, R1, R2, R3} reg_id_t;

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} ldr_state_t;

  // Number of host beats needed to fill the given register.
  function automatic int unsigned words_for(input reg_id_t id, input int unsigned host_w);
    return (id == R3) ? (R3_W / host_w) : (REG_W / host_w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_bank_loader_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : word_assembler
// Description : Staging shift register and beat counter for host loads.
//               Flags the beat that completes the requested word count.
// Revision    : 1.0 - initial release
// ============================================================================
module word_assembler
  import aes_pkg::*;
#(
  parameter int HOST_W = 32,
  parameter int CNT_W  = $clog2(REG_W / HOST_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              beat,     // a host word is accepted this cycle
  input  logic              first,    // the accepted word starts a new load
  input  logic [HOST_W-1:0] data,
  input  logic [CNT_W-1:0]  need,     // words required by the current target
  output logic [REG_W-1:0]  staging,
  output logic              done      // this beat completes the load
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  // Count after the current beat: a first beat restarts at one.
  always_comb begin
    count_next = first ? CNT_W'(1) : count + CNT_W'(1);
    done       = beat && (count_next == need);
  end

  // Shift words in most-significant first; a first beat clears older data.
  always_ff @(posedge clk) begin
    if (rst) begin
      staging <= '0;
      count   <= '0;
    end else if (beat) begin
      count <= count_next;
      if (first) begin
        staging <= {{(REG_W - HOST_W){1'b0}}, data};
      end else begin
        staging <= {staging[REG_W-HOST_W-1:0], data};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_bank_loader.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_loader
// Description : Owns AES working registers r0..r3. Loads them from a host
//               valid/ready word stream or from a busC datapath write-back.
//               A write-back to the commit target defers the host commit.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank_loader
  import aes_pkg::*;
#(
  parameter int HOST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [HOST_W-1:0] host_data,
  input  logic [1:0]        host_addr,
  input  logic              WE_busC,
  input  logic [1:0]        SEL_busC,
  input  logic [REG_W-1:0]  busC,
  output logic [REG_W-1:0]  r0,
  output logic [REG_W-1:0]  r1,
  output logic [REG_W-1:0]  r2,
  output logic [R3_W-1:0]   r3,
  output logic              busy,
  output logic              load_done
);

  localparam int CNT_W = $clog2(REG_W / HOST_W + 1);

  ldr_state_t       state;
  ldr_state_t       state_next;
  reg_id_t          target;
  reg_id_t          beat_target;
  logic             accept;
  logic             first_beat;
  logic             asm_done;
  logic [CNT_W-1:0] need;
  logic [REG_W-1:0] staging;
  logic             collide;
  logic             commit_ok;

  // Beat acceptance and the target used for the beat-count lookup.
  always_comb begin
    accept      = host_valid && host_ready;
    first_beat  = (state == IDLE);
    beat_target = first_beat ? reg_id_t'(host_addr) : target;
    need        = CNT_W'(words_for(beat_target, HOST_W));
    collide     = WE_busC && (reg_id_t'(SEL_busC) == target);
    commit_ok   = (state == COMMIT) && !collide;
  end

  word_assembler #(
    .HOST_W (HOST_W),
    .CNT_W  (CNT_W)
  ) u_word_assembler (
    .clk     (clk),
    .rst     (rst),
    .beat    (accept),
    .first   (first_beat),
    .data    (host_data),
    .need    (need),
    .staging (staging),
    .done    (asm_done)
  );

  // State register, load target and the delayed completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      target    <= R0;
      load_done <= 1'b0;
    end else begin
      state     <= state_next;
      load_done <= commit_ok;
      if (accept && first_beat) begin
        target <= reg_id_t'(host_addr);
      end
    end
  end

  // Next-state selection; a colliding write-back holds COMMIT for a retry.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = asm_done ? COMMIT : LOAD;
      LOAD:    if (accept && asm_done) state_next = COMMIT;
      COMMIT:  if (commit_ok) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    host_ready = (state == IDLE) || (state == LOAD);
    busy       = (state == LOAD) || (state == COMMIT);
  end

  // Register bank: write-back and commit never hit the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r0 <= '0;
      r1 <= '0;
      r2 <= '0;
      r3 <= '0;
    end else begin
      if (WE_busC) begin
        case (reg_id_t'(SEL_busC))
          R0:      r0 <= busC;
          R1:      r1 <= busC;
          R2:      r2 <= busC;
          default: r3 <= busC[R3_W-1:0];
        endcase
      end
      if (commit_ok) begin
        case (target)
          R0:      r0 <= staging;
          R1:      r1 <= staging;
          R2:      r2 <= staging;
          default: r3 <= staging[R3_W-1:0];
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_bank_loader
// Description : Directed vector tables, a gapped-load sequence and random
//               traffic, all checked against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bank_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         host_valid;
  logic         host_ready;
  logic [31:0]  host_data;
  logic [1:0]   host_addr;
  logic         WE_busC;
  logic [1:0]   SEL_busC;
  logic [127:0] busC;
  logic [127:0] r0, r1, r2;
  logic [63:0]  r3;
  logic         busy;
  logic         load_done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reg_bank_loader #(.HOST_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_data  (host_data),
    .host_addr  (host_addr),
    .WE_busC    (WE_busC),
    .SEL_busC   (SEL_busC),
    .busC       (busC),
    .r0         (r0),
    .r1         (r1),
    .r2         (r2),
    .r3         (r3),
    .busy       (busy),
    .load_done  (load_done)
  );

  typedef struct {
    bit           rst;
    bit           valid;
    logic [31:0]  data;
    logic [1:0]   addr;
    bit           we;
    logic [1:0]   sel;
    logic [127:0] busc;
    bit           e_ready;
    bit           e_busy;
    bit           e_done;
    int           chk;      // register to check after the edge, -1 for none
    logic [127:0] e_val;
  } vec_t;

  vec_t vecs[$];

  // Reference model: pending words, target, commit-pending flag, registers.
  logic [127:0] m_r[4];
  logic [31:0]  m_words[$];
  logic [1:0]   m_target;
  bit           m_commit;
  bit           m_done;
  bit           armed = 0;

  function automatic vec_t v(bit r, bit vl, logic [31:0] d, logic [1:0] a, bit we, logic [1:0] s,
                             logic [127:0] bc, bit er, bit eb, bit ed, int ck, logic [127:0] ev);
    vec_t x;
    x.rst = r; x.valid = vl; x.data = d; x.addr = a; x.we = we; x.sel = s; x.busc = bc;
    x.e_ready = er; x.e_busy = eb; x.e_done = ed; x.chk = ck; x.e_val = ev;
    return x;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] dut_reg(int i);
    case (i)
      0:       return r0;
      1:       return r1;
      2:       return r2;
      default: return {64'b0, r3};
    endcase
  endfunction

  task automatic model_check();
    chk("model_ready", {127'b0, host_ready}, {127'b0, !m_commit});
    chk("model_busy", {127'b0, busy}, {127'b0, (m_commit || m_words.size() != 0)});
    chk("model_done", {127'b0, load_done}, {127'b0, m_done});
    for (int i = 0; i < 4; i++) chk($sformatf("model_r%0d", i), dut_reg(i), m_r[i]);
  endtask

  task automatic model_step(input vec_t x);
    logic [127:0] val;
    bit committed;
    if (x.rst) begin
      for (int i = 0; i < 4; i++) m_r[i] = '0;
      m_words.delete();
      m_commit = 0;
      m_done   = 0;
      m_target = 2'd0;
      return;
    end
    committed = m_commit && !(x.we && x.sel == m_target);
    if (x.we) m_r[x.sel] = (x.sel == 2'd3) ? {64'b0, x.busc[63:0]} : x.busc;
    if (committed) begin
      val = '0;
      foreach (m_words[i]) val = (val << 32) | {96'b0, m_words[i]};
      m_r[m_target] = val;
      m_words.delete();
      m_commit = 0;
    end else if (!m_commit && x.valid) begin
      if (m_words.size() == 0) m_target = x.addr;
      m_words.push_back(x.data);
      if (m_words.size() == ((m_target == 2'd3) ? 2 : 4)) m_commit = 1;
    end
    m_done = committed;
  endtask

  // One clock: drive, compare model before the edge, step model, settle.
  task automatic apply(input vec_t x);
    rst = x.rst; host_valid = x.valid; host_data = x.data; host_addr = x.addr;
    WE_busC = x.we; SEL_busC = x.sel; busC = x.busc;
    if (armed) model_check();
    @(posedge clk);
    model_step(x);
    #1;
    armed = 1;
  endtask

  task automatic run_table();
    foreach (vecs[i]) begin
      apply(vecs[i]);
      chk($sformatf("vec%0d_ready", i), {127'b0, host_ready}, {127'b0, vecs[i].e_ready});
      chk($sformatf("vec%0d_busy", i), {127'b0, busy}, {127'b0, vecs[i].e_busy});
      chk($sformatf("vec%0d_done", i), {127'b0, load_done}, {127'b0, vecs[i].e_done});
      if (vecs[i].chk >= 0)
        chk($sformatf("vec%0d_r%0d", i, vecs[i].chk), dut_reg(vecs[i].chk), vecs[i].e_val);
    end
    vecs.delete();
  endtask

  localparam logic [127:0] HV1   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] HV2   = 128'h01020304_05060708_090A0B0C_0D0E0F10;
  localparam logic [127:0] HV3   = 128'hCAFEF00D_12345678_9ABCDEF0_0BADC0DE;
  localparam logic [127:0] ONES  = {128{1'b1}};
  localparam logic [127:0] A5S   = {16{8'hA5}};
  localparam logic [127:0] FIVES = {32{4'h5}};
  localparam logic [127:0] Z     = 128'b0;

  initial begin
    logic [31:0] w1[4];
    logic [31:0] w2[4];
    logic [31:0] w3[4];
    int beat;
    bit b;
    w1[0] = 32'h00112233; w1[1] = 32'h44556677; w1[2] = 32'h8899AABB; w1[3] = 32'hCCDDEEFF;
    w2[0] = 32'h01020304; w2[1] = 32'h05060708; w2[2] = 32'h090A0B0C; w2[3] = 32'h0D0E0F10;
    w3[0] = 32'hCAFEF00D; w3[1] = 32'h12345678; w3[2] = 32'h9ABCDEF0; w3[3] = 32'h0BADC0DE;
    rst = 1; host_valid = 0; host_data = 0; host_addr = 0; WE_busC = 0; SEL_busC = 0; busC = 0;
    @(posedge clk);

    // Reset, back-to-back load of r1, then r3 with a held-off third word.
    vecs.push_back(v(1, 0, 0, 0, 0, 0, Z, 1, 0, 0, 1, Z));
    for (int i = 0; i < 4; i++) vecs.push_back(v(0, 1, w1[i], 1, 0, 0, Z, i < 3, 1, 0, -1, Z));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, Z, 1, 0, 1, 1, HV1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, Z, 1, 0, 0, 0, Z));
    vecs.push_back(v(0, 1, 32'hDEADBEEF, 3, 0, 0, Z, 1, 1, 0, -1, Z));
    vecs.push_back(v(0, 1, 32'h01234567, 0, 0, 0, Z, 0, 1, 0, -1, Z));
    vecs.push_back(v(0, 1, 32'hFFFFFFFF, 0, 0, 0, Z, 1, 0, 1, 3, {64'b0, 64'hDEADBEEF01234567}));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, Z, 1, 0, 0, 3, {64'b0, 64'hDEADBEEF01234567}));
    // Colliding write-back to r2 during COMMIT stalls the commit by one cycle.
    for (int i = 0; i < 4; i++) vecs.push_back(v(0, 1, w2[i], 2, 0, 0, Z, i < 3, 1, 0, -1, Z));
    vecs.push_back(v(0, 0, 0, 0, 1, 2, ONES, 0, 1, 0, 2, ONES));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, Z, 1, 0, 1, 2, HV2));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, Z, 1, 0, 0, -1, Z));
    // Write-back to r0 in parallel with the r2 commit.
    for (int i = 0; i < 4; i++) vecs.push_back(v(0, 1, w3[i], 2, 0, 0, Z, i < 3, 1, 0, -1, Z));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, A5S, 1, 0, 1, 0, A5S));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, Z, 1, 0, 0, 2, HV3));
    // Reset mid-load discards the partial load, then a fresh load succeeds.
    vecs.push_back(v(0, 0, 0, 0, 1, 1, FIVES, 1, 0, 0, 1, FIVES));
    vecs.push_back(v(0, 1, w2[0], 1, 0, 0, Z, 1, 1, 0, -1, Z));
    vecs.push_back(v(0, 1, w2[1], 1, 0, 0, Z, 1, 1, 0, -1, Z));
    vecs.push_back(v(1, 1, w2[2], 1, 0, 0, Z, 1, 0, 0, 1, Z));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, Z, 1, 0, 0, 1, Z));
    for (int i = 0; i < 4; i++) vecs.push_back(v(0, 1, w1[i], 1, 0, 0, Z, i < 3, 1, 0, -1, Z));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, Z, 1, 0, 1, 1, HV1));
    run_table();

    // Gapped beats on cycles 0, 3, 4, 9; later beats carry a bogus address.
    beat = 0;
    for (int c = 0; c < 10; c++) begin
      b = (c == 0) || (c == 3) || (c == 4) || (c == 9);
      apply(v(0, b, b ? w1[beat] : 32'h0, (beat == 0) ? 2'd0 : 2'd3, 0, 0, Z, 0, 0, 0, -1, Z));
      if (b) beat++;
      chk($sformatf("gap_busy_c%0d", c), {127'b0, busy}, {127'b0, 1'b1});
    end
    apply(v(0, 0, 0, 0, 0, 0, Z, 0, 0, 0, -1, Z));
    chk("gap_r0", r0, HV1);
    chk("gap_done", {127'b0, load_done}, {127'b0, 1'b1});

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      apply(v($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 6, $urandom,
              2'($urandom_range(0, 3)), $urandom_range(0, 4) == 0, 2'($urandom_range(0, 3)),
              {$urandom, $urandom, $urandom, $urandom}, 0, 0, 0, -1, Z));
    end
    model_check();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
